// File: rtl/pwm_seq.sv
// Command sequencer for one PWM channel: turns host commands into single-cycle
// register writes and runs autonomous compare-value ramps toward a target.
module pwm_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    input  logic [W-1:0] cmd_step,
    input  logic [W-1:0] cmd_interval,
    input  logic         cmd_abort,
    output logic [W-1:0] pwm_d,
    output logic [1:0]   pwm_sel,
    output logic         busy,
    output logic [W-1:0] cur_cmp
);

    typedef enum logic [1:0] {IDLE, WRITE, RAMP_WAIT, RAMP_WRITE} state_t;

    localparam logic [1:0] OP_SET_TOP  = 2'd0;
    localparam logic [1:0] OP_SET_CMP  = 2'd1;
    localparam logic [1:0] OP_RAMP_CMP = 2'd2;
    localparam logic [1:0] SEL_NONE    = 2'd0;
    localparam logic [1:0] SEL_CMP     = 2'd1;
    localparam logic [1:0] SEL_TOP     = 2'd2;
    localparam logic [1:0] SEL_CNT     = 2'd3;
    localparam logic [W-1:0] ONE       = W'(1);

    state_t       state, state_nx;
    logic [W-1:0] timer, timer_nx;
    logic [W-1:0] target, target_nx;
    logic [W-1:0] step, step_nx;
    logic [W-1:0] interval, interval_nx;
    logic [W-1:0] pwm_d_nx, cur_cmp_nx;
    logic [1:0]   pwm_sel_nx;
    logic [W:0]   up_gap, down_gap;
    logic [W-1:0] ramp_next;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // Gaps are one bit wider so the clamp to target can never overshoot or wrap.
    always_comb begin
        up_gap   = {1'b0, target} - {1'b0, cur_cmp};
        down_gap = {1'b0, cur_cmp} - {1'b0, target};
        if (cur_cmp < target)
            ramp_next = (up_gap <= {1'b0, step}) ? target : cur_cmp + step;
        else
            ramp_next = (down_gap <= {1'b0, step}) ? target : cur_cmp - step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            target   <= '0;
            step     <= '0;
            interval <= '0;
            pwm_d    <= '0;
            pwm_sel  <= SEL_NONE;
            cur_cmp  <= '0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            target   <= target_nx;
            step     <= step_nx;
            interval <= interval_nx;
            pwm_d    <= pwm_d_nx;
            pwm_sel  <= pwm_sel_nx;
            cur_cmp  <= cur_cmp_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        target_nx   = target;
        step_nx     = step;
        interval_nx = interval;
        pwm_d_nx    = pwm_d;
        pwm_sel_nx  = SEL_NONE;
        cur_cmp_nx  = cur_cmp;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        OP_SET_TOP: begin
                            pwm_sel_nx = SEL_TOP;
                            pwm_d_nx   = cmd_data;
                            state_nx   = WRITE;
                        end
                        OP_SET_CMP: begin
                            pwm_sel_nx = SEL_CMP;
                            pwm_d_nx   = cmd_data;
                            cur_cmp_nx = cmd_data;
                            state_nx   = WRITE;
                        end
                        OP_RAMP_CMP: begin
                            target_nx   = cmd_data;
                            step_nx     = (cmd_step == '0) ? ONE : cmd_step;
                            interval_nx = cmd_interval;
                            if (cmd_data != cur_cmp) begin
                                timer_nx = cmd_interval;
                                state_nx = RAMP_WAIT;
                            end
                        end
                        default: begin
                            pwm_sel_nx = SEL_CNT;
                            pwm_d_nx   = cmd_data;
                            state_nx   = WRITE;
                        end
                    endcase
                end
            end
            WRITE: state_nx = IDLE;
            RAMP_WAIT: begin
                if (cmd_abort) begin
                    state_nx = IDLE;
                end else if (timer == '0) begin
                    pwm_sel_nx = SEL_CMP;
                    pwm_d_nx   = ramp_next;
                    cur_cmp_nx = ramp_next;
                    state_nx   = RAMP_WRITE;
                end else begin
                    timer_nx = timer - ONE;
                end
            end
            RAMP_WRITE: begin
                if (cmd_abort || (cur_cmp == target)) begin
                    state_nx = IDLE;
                end else begin
                    timer_nx = interval;
                    state_nx = RAMP_WAIT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pwm_seq.sv
// Bench for pwm_seq: a write-schedule model predicts every pulse, ready and busy
// cycle; directed scenarios pin the model with literal expectations.
module tb_pwm_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_data = '0;
    logic [15:0] cmd_step = '0;
    logic [15:0] cmd_interval = '0;
    logic        cmd_abort = 1'b0;
    logic [15:0] pwm_d;
    logic [1:0]  pwm_sel;
    logic        busy;
    logic [15:0] cur_cmp;

    pwm_seq #(.W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_step(cmd_step),
        .cmd_interval(cmd_interval), .cmd_abort(cmd_abort), .pwm_d(pwm_d),
        .pwm_sel(pwm_sel), .busy(busy), .cur_cmp(cur_cmp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [1:0] sel;
        logic [15:0] d;
    } wr_t;

    wr_t         wq[$];
    wr_t         plog[$];
    bit          ready_hist[int];
    int          cyc = 0;
    int          idle_at = 0;
    logic [15:0] m_cur = '0;
    logic [15:0] m_d = '0;
    bit          ramp_active = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic pushWrite(input int c, input logic [1:0] sel, input logic [15:0] d);
        wr_t w;
        w.c = c;
        w.sel = sel;
        w.d = d;
        wq.push_back(w);
    endtask

    // One clock cycle: drive inputs, compare DUT against the schedule, then fold
    // the inputs sampled at the coming edge into the schedule.
    task automatic applyStimulus(input bit r, input bit v, input logic [1:0] op,
                                 input logic [15:0] data, input logic [15:0] st,
                                 input logic [15:0] iv, input bit ab);
        logic [1:0]  e_sel;
        logic [15:0] e_d;
        bit          e_ready, e_busy;
        wr_t         w;
        int          c, t, s, k;
        @(negedge clk);
        rst = r; cmd_valid = v; cmd_op = op; cmd_data = data;
        cmd_step = st; cmd_interval = iv; cmd_abort = ab;
        #1;
        e_sel = 2'd0;
        if (wq.size() > 0 && wq[0].c == cyc) begin
            w = wq.pop_front();
            e_sel = w.sel;
            m_d = w.d;
            if (w.sel == 2'd1) m_cur = w.d;
        end
        e_d = m_d;
        e_ready = !r && (cyc >= idle_at);
        e_busy = (cyc < idle_at);
        checkOutput("pwm_sel", pwm_sel, e_sel);
        checkOutput("pwm_d", pwm_d, e_d);
        checkOutput("cur_cmp", cur_cmp, m_cur);
        checkOutput("cmd_ready", cmd_ready, e_ready);
        checkOutput("busy", busy, e_busy);
        ready_hist[cyc] = cmd_ready;
        if (pwm_sel != 2'd0) begin
            w.c = cyc; w.sel = pwm_sel; w.d = pwm_d;
            plog.push_back(w);
        end
        if (r) begin
            wq.delete();
            idle_at = cyc + 1;
            m_cur = '0;
            m_d = '0;
            ramp_active = 0;
        end else begin
            if (ab && ramp_active && cyc < idle_at) begin
                while (wq.size() > 0 && wq[wq.size()-1].c > cyc) void'(wq.pop_back());
                idle_at = cyc + 1;
            end
            if (v && e_ready) begin
                ramp_active = (op == 2'd2);
                case (op)
                    2'd0: begin pushWrite(cyc + 1, 2'd2, data); idle_at = cyc + 2; end
                    2'd1: begin pushWrite(cyc + 1, 2'd1, data); idle_at = cyc + 2; end
                    2'd3: begin pushWrite(cyc + 1, 2'd3, data); idle_at = cyc + 2; end
                    default: begin
                        c = int'(m_cur);
                        t = int'(data);
                        s = (st == 16'd0) ? 1 : int'(st);
                        k = 0;
                        while (c != t) begin
                            k++;
                            if (c < t) c = (t - c <= s) ? t : c + s;
                            else       c = (c - t <= s) ? t : c - s;
                            pushWrite(cyc + k * (int'(iv) + 2), 2'd1, c[15:0]);
                        end
                        idle_at = cyc + k * (int'(iv) + 2) + 1;
                    end
                endcase
            end
        end
        cyc++;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] data,
                       input logic [15:0] st, input logic [15:0] iv);
        applyStimulus(0, 1, op, data, st, iv, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 0);
    endtask

    task automatic checkPulse(input string name, input int idx, input int t0, input int off,
                              input logic [1:0] sel, input logic [15:0] d);
        if (idx < plog.size()) begin
            checkOutput({name, "_cycle"}, plog[idx].c - t0, off);
            checkOutput({name, "_sel"}, plog[idx].sel, sel);
            checkOutput({name, "_d"}, plog[idx].d, d);
        end else begin
            checkOutput({name, "_present"}, plog.size(), idx + 1);
        end
    endtask

    initial begin
        int t0;
        logic [15:0] st, tgt;
        int cur, diff, delta;

        @(posedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 2'd0, 16'h1234, 16'h0, 16'h0, 0);
        checkOutput("rst_ready", cmd_ready, 0);
        checkOutput("rst_sel", pwm_sel, 0);
        checkOutput("rst_d", pwm_d, 0);
        checkOutput("rst_cur", cur_cmp, 0);
        checkOutput("rst_busy", busy, 0);

        plog.delete();
        t0 = cyc;
        cmd(2'd0, 16'h03E8, 0, 0);
        cmd(2'd1, 16'h0100, 0, 0);
        cmd(2'd1, 16'h0100, 0, 0);
        idle(3);
        checkPulse("set_top", 0, t0, 1, 2'd2, 16'h03E8);
        checkPulse("set_cmp", 1, t0, 3, 2'd1, 16'h0100);
        checkOutput("set_ready_c1", ready_hist[t0+1], 0);
        checkOutput("set_ready_c2", ready_hist[t0+2], 1);
        checkOutput("set_cur", cur_cmp, 16'h0100);

        cmd(2'd1, 16'h0000, 0, 0); idle(1);
        plog.delete();
        t0 = cyc;
        cmd(2'd2, 16'd10, 16'd3, 16'd1);
        idle(15);
        checkOutput("up_count", plog.size(), 4);
        checkPulse("up_w0", 0, t0, 3, 2'd1, 16'd3);
        checkPulse("up_w1", 1, t0, 6, 2'd1, 16'd6);
        checkPulse("up_w2", 2, t0, 9, 2'd1, 16'd9);
        checkPulse("up_w3", 3, t0, 12, 2'd1, 16'd10);
        checkOutput("up_ready_c12", ready_hist[t0+12], 0);
        checkOutput("up_ready_c13", ready_hist[t0+13], 1);

        plog.delete();
        t0 = cyc;
        cmd(2'd2, 16'd0, 16'd4, 16'd0);
        idle(8);
        checkOutput("down_count", plog.size(), 3);
        checkPulse("down_w0", 0, t0, 2, 2'd1, 16'd6);
        checkPulse("down_w1", 1, t0, 4, 2'd1, 16'd2);
        checkPulse("down_w2", 2, t0, 6, 2'd1, 16'd0);

        cmd(2'd1, 16'd10, 0, 0); idle(1);
        plog.delete();
        t0 = cyc;
        cmd(2'd2, 16'd2, 16'd0, 16'd0);
        idle(18);
        checkOutput("step0_count", plog.size(), 8);
        checkPulse("step0_first", 0, t0, 2, 2'd1, 16'd9);
        checkPulse("step0_last", 7, t0, 16, 2'd1, 16'd2);

        plog.delete();
        t0 = cyc;
        cmd(2'd2, 16'd2, 16'd5, 16'd3);
        idle(3);
        checkOutput("equal_count", plog.size(), 0);
        checkOutput("equal_ready_c1", ready_hist[t0+1], 1);

        cmd(2'd1, 16'd0, 0, 0); idle(1);
        plog.delete();
        t0 = cyc;
        cmd(2'd2, 16'd100, 16'd10, 16'd5);
        idle(15);
        applyStimulus(0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 1);
        idle(20);
        checkOutput("abort_count", plog.size(), 2);
        checkPulse("abort_w1", 1, t0, 14, 2'd1, 16'd20);
        checkOutput("abort_ready_c16", ready_hist[t0+16], 0);
        checkOutput("abort_ready_c17", ready_hist[t0+17], 1);
        checkOutput("abort_cur", cur_cmp, 16'd20);

        cmd(2'd1, 16'hFFF0, 0, 0); idle(1);
        plog.delete();
        t0 = cyc;
        cmd(2'd2, 16'hFFFF, 16'h0020, 16'd0);
        idle(5);
        checkOutput("wrap_count", plog.size(), 1);
        checkPulse("wrap_w0", 0, t0, 2, 2'd1, 16'hFFFF);
        checkOutput("wrap_cur", cur_cmp, 16'hFFFF);

        // Random traffic with occasional aborts and resets; ramps are shaped so
        // that each one stays short.
        for (int n = 0; n < 4000; n++) begin
            cur = int'(m_cur);
            tgt = 16'($urandom_range(0, 65535));
            st = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) begin
                delta = $urandom_range(0, 20);
                if ($urandom_range(0, 1) == 1) tgt = 16'((cur + delta > 65535) ? 65535 : cur + delta);
                else                           tgt = 16'((cur - delta < 0) ? 0 : cur - delta);
                st = 16'($urandom_range(0, 5));
            end else begin
                diff = (int'(tgt) > cur) ? int'(tgt) - cur : cur - int'(tgt);
                st = 16'($urandom_range(diff / 16 + 1, 65535));
            end
            applyStimulus($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), tgt, st,
                          16'($urandom_range(0, 4)), $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_seq.md
# pwm_seq

Command sequencer that owns the register-write port (`d`/`sel`) of one PWM channel. It accepts host commands over a valid/ready handshake and turns them into single-cycle register writes. It also runs autonomous duty-cycle ramps: the compare value steps toward a target at a programmable rate. It sits between the control/host logic and the PWM generator, and is the only driver of that generator's write port.

## Interface
- `W`, 16, data width of PWM registers and command operands

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  sequencer can accept a command this cycle
- `cmd_op`  in  2  0=SET_TOP, 1=SET_CMP, 2=RAMP_CMP, 3=SET_CNT
- `cmd_data`  in  W  register value (SET_*) or ramp target (RAMP_CMP)
- `cmd_step`  in  W  ramp step size (RAMP_CMP only)
- `cmd_interval`  in  W  ramp wait cycles between writes (RAMP_CMP only)
- `cmd_abort`  in  1  stop an in-progress ramp
- `pwm_d`  out  W  write data to PWM
- `pwm_sel`  out  2  write select: 0=none, 1=cmp, 2=top, 3=cnt
- `busy`  out  1  state is not IDLE
- `cur_cmp`  out  W  last compare value written by this block

## Operation
- States: IDLE, WRITE, RAMP_WAIT, RAMP_WRITE.
- `cmd_ready` = (state==IDLE) && !rst. A command is accepted on an edge where `cmd_valid && cmd_ready`.
- `pwm_sel` and `pwm_d` are registered. `pwm_sel` is nonzero for exactly one cycle per write and 0 otherwise. `pwm_d` holds its last value when `pwm_sel`=0.
- SET_TOP / SET_CMP / SET_CNT:
  - Accept → WRITE, with `pwm_sel`=2/1/3 and `pwm_d`=`cmd_data`.
  - SET_CMP also loads `cur_cmp`=`cmd_data`.
  - WRITE → IDLE, with `pwm_sel`=0.
- RAMP_CMP:
  - Accept latches target, step, interval. A step of 0 is treated as 1.
  - If target==`cur_cmp`: stay in IDLE, no write.
  - Otherwise → RAMP_WAIT with timer=interval.
- RAMP_WAIT:
  - Timer decrements by 1 each cycle.
  - On the cycle timer==0: compute next, → RAMP_WRITE with `pwm_sel`=1, `pwm_d`=next, `cur_cmp`=next.
- next:
  - If `cur_cmp` < target: next = target when (target−`cur_cmp`) ≤ step, else `cur_cmp`+step.
  - Descending is symmetric.
  - Differences are computed in W+1 bits. next never overshoots the target and never wraps.
- RAMP_WRITE:
  - `pwm_sel`=0.
  - If `cur_cmp`==target → IDLE.
  - Otherwise → RAMP_WAIT with timer=interval.
- `cmd_abort` sampled in RAMP_WAIT → IDLE immediately, no further write, `cur_cmp` keeps the last written value.
- `cmd_abort` sampled in RAMP_WRITE → IDLE after that write; the write itself completes.
- `cmd_abort` is ignored in IDLE and WRITE.
- `cmd_*` fields other than `cmd_valid` and `cmd_abort` are don't-care when no command is accepted.

## Timing
- Reset values, applied while `rst` is high: state=IDLE, `pwm_sel`=0, `pwm_d`=0, `cur_cmp`=0, `busy`=0, `cmd_ready`=0.
- Reset mid-ramp or mid-write aborts at once. No write pulse appears in the cycle after reset is sampled.
- Single-write latency: accept at cycle 0 → `pwm_sel` pulse in cycle 1 → `cmd_ready` high again in cycle 2. Maximum throughput is one command per 2 cycles.
- Ramp: accept at cycle 0 → first write pulse in cycle interval+2. Later writes are spaced interval+2 cycles apart.
- `cmd_ready` returns in the cycle after the final write pulse.
- `busy` is high exactly when `cmd_ready` would be low for a non-reset reason.
- `cur_cmp` changes on the same edge that raises `pwm_sel`=1.

## Test plan
- Reset: hold `rst` 3 cycles with `cmd_valid`=1 → `cmd_ready`=0, `pwm_sel`=0, `pwm_d`=0, `cur_cmp`=0, no command accepted.
- SET_TOP 0x03E8, then SET_CMP 0x0100 back-to-back (valid held) → `pwm_sel`=2/`pwm_d`=0x03E8 in cycle 1, `pwm_sel`=1/`pwm_d`=0x0100 in cycle 3, `cur_cmp`=0x0100.
- Up ramp: `cur_cmp`=0, RAMP_CMP target 10, step 3, interval 1 → writes 3, 6, 9, 10 in cycles 3, 6, 9, 12; `cmd_ready`=1 in cycle 13.
- Down ramp: `cur_cmp`=10, target 0, step 4, interval 0 → writes 6, 2, 0 spaced 2 cycles apart, no underflow. Step 0 with target 2 → writes 9, 8, …, 2, one per step of 1.
- Abort: ramp 0→100, step 10, interval 5. Assert `cmd_abort` during the wait after the second write → IDLE the next cycle, `cur_cmp`=20, no further pulses.
- Edge cases:
  - RAMP_CMP with target==`cur_cmp` → no write, `cmd_ready` high in cycle 1.
  - Ramp 0xFFF0→0xFFFF with step 0x0020 → single write 0xFFFF, no wrap.
